// File: rtl/booth_pkg.sv
// Shared constants and result-entry type for the Booth multiplier datapath.
// BOOTH_COLLECT_TAG_EN adds a sequence tag to every buffered result entry.
package booth_pkg;

    localparam int DEFAULT_OUTPUT_WIDTH = 12;
    localparam int DEFAULT_COUNTER_SIZE = 3;
    localparam int DEFAULT_DONE_COUNT   = 7;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int DEFAULT_TAG_WIDTH    = 4;

`ifdef BOOTH_COLLECT_TAG_EN
    localparam bit TAG_EN = 1'b1;

    typedef struct packed {
        logic [DEFAULT_TAG_WIDTH-1:0]    tag;
        logic [DEFAULT_OUTPUT_WIDTH-1:0] product;
    } result_entry_t;
`else
    localparam bit TAG_EN = 1'b0;

    typedef struct packed {
        logic [DEFAULT_OUTPUT_WIDTH-1:0] product;
    } result_entry_t;
`endif

    // Packed width of one stored entry: {tag, product} or just product.
    function automatic int entry_width(input int product_w, input int tag_w);
        return TAG_EN ? product_w + tag_w : product_w;
    endfunction

endpackage

// File: rtl/booth_result_fifo.sv
// Circular result buffer: storage, read/write pointers, occupancy and full/empty.
// A write request arriving while full is accepted only if a pop frees a slot.
module booth_result_fifo #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    wr_req,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    dropped,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [LVL_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = !empty && rd_ready;
    assign push    = wr_req && (!full || pop);
    assign dropped = wr_req && full && !pop;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Gate the head so an empty buffer presents zeros rather than stale storage.
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign rd_valid = !empty;
    assign level    = count;

endmodule

// File: rtl/booth_result_collector.sv
// Captures each completed Booth product on the rising edge of counter==DONE_COUNT
// and buffers it for a valid/ready consumer. Optional tag: BOOTH_COLLECT_TAG_EN.
module booth_result_collector
    import booth_pkg::*;
#(
    parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
    parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE,
    parameter int DONE_COUNT   = DEFAULT_DONE_COUNT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int TAG_WIDTH    = DEFAULT_TAG_WIDTH
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [OUTPUT_WIDTH-1:0]       product_in,
    input  logic [COUNTER_SIZE-1:0]       counter_in,
    input  logic                          ready_in,
    output logic [OUTPUT_WIDTH-1:0]       result_out,
    output logic                          valid_out,
    output logic                          overflow_out,
    output logic [$clog2(FIFO_DEPTH):0]   level_out
`ifdef BOOTH_COLLECT_TAG_EN
    ,
    output logic [TAG_WIDTH-1:0]          tag_out
`endif
);

    localparam int ENTRY_W = entry_width(OUTPUT_WIDTH, TAG_WIDTH);

    logic               match;
    logic               match_q;
    logic               capture;
    logic               dropped;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_data;

    // A counter parked on DONE_COUNT yields a single capture on its first cycle.
    assign match   = (counter_in == COUNTER_SIZE'(DONE_COUNT));
    assign capture = match && !match_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            match_q      <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            match_q <= match;
            if (dropped) overflow_out <= 1'b1;
        end
    end

`ifdef BOOTH_COLLECT_TAG_EN
    logic [TAG_WIDTH-1:0] tag_cnt;

    // Dropped captures still consume a tag so the consumer can spot the gap.
    always_ff @(posedge clk_in) begin
        if (!rst_in)      tag_cnt <= '0;
        else if (capture) tag_cnt <= tag_cnt + 1'b1;
    end

    assign wr_data    = {tag_cnt, product_in};
    assign result_out = rd_data[OUTPUT_WIDTH-1:0];
    assign tag_out    = rd_data[ENTRY_W-1:OUTPUT_WIDTH];
`else
    assign wr_data    = product_in;
    assign result_out = rd_data;
`endif

    booth_result_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .wr_req   (capture),
        .wr_data  (wr_data),
        .rd_ready (ready_in),
        .rd_data  (rd_data),
        .rd_valid (valid_out),
        .dropped  (dropped),
        .level    (level_out)
    );

endmodule

// File: tb/tb_booth_result_collector.sv
// Randomized and directed bench for booth_result_collector against a queue model.
// Tag checks are compiled in when BOOTH_COLLECT_TAG_EN is defined.
module tb_booth_result_collector;

    localparam int OW    = 12;
    localparam int CS    = 3;
    localparam int DC    = 7;
    localparam int DEPTH = 4;
    localparam int TW    = 2;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [OW-1:0] product_in;
    logic [CS-1:0] counter_in;
    logic          ready_in;
    logic [OW-1:0] result_out;
    logic          valid_out;
    logic          overflow_out;
    logic [2:0]    level_out;
`ifdef BOOTH_COLLECT_TAG_EN
    logic [TW-1:0] tag_out;
`endif

    always #5 clk_in = ~clk_in;

    booth_result_collector #(
        .OUTPUT_WIDTH (OW),
        .COUNTER_SIZE (CS),
        .DONE_COUNT   (DC),
        .FIFO_DEPTH   (DEPTH),
        .TAG_WIDTH    (TW)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .product_in   (product_in),
        .counter_in   (counter_in),
        .ready_in     (ready_in),
        .result_out   (result_out),
        .valid_out    (valid_out),
        .overflow_out (overflow_out),
        .level_out    (level_out)
`ifdef BOOTH_COLLECT_TAG_EN
        ,
        .tag_out      (tag_out)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of completed products.
    typedef struct {
        logic [OW-1:0] p;
        int            t;
    } ent_t;

    ent_t q[$];
    bit   prev_match  = 1'b0;
    bit   m_ovf       = 1'b0;
    bit   model_live  = 1'b0;
    int   m_tag       = 0;

    always @(posedge clk_in) begin
        bit m;
        bit cap;
        bit pop;
        bit was_full;
        if (!rst_in) begin
            q.delete();
            prev_match = 1'b0;
            m_ovf      = 1'b0;
            m_tag      = 0;
        end else begin
            m          = (counter_in == DC);
            cap        = m && !prev_match;
            prev_match = m;
            pop        = (q.size() > 0) && ready_in;
            was_full   = (q.size() == DEPTH);
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (was_full && !pop) m_ovf = 1'b1;
                else                  q.push_back('{p: product_in, t: m_tag});
                m_tag = (m_tag + 1) % (1 << TW);
            end
        end
        model_live = 1'b1;
    end

    always @(negedge clk_in) begin
        if (model_live) begin
            check("valid_out", valid_out, q.size() > 0);
            check("level_out", level_out, q.size());
            check("overflow_out", overflow_out, m_ovf);
            if (q.size() > 0) begin
                check("result_out", result_out, q[0].p);
`ifdef BOOTH_COLLECT_TAG_EN
                check("tag_out", tag_out, q[0].t);
`endif
            end
        end
    end

    // Inputs are applied just after an edge and sampled by the next one.
    task automatic cyc(input logic n, input int c, input logic [OW-1:0] p, input logic r);
        rst_in     = n;
        counter_in = c[CS-1:0];
        product_in = p;
        ready_in   = r;
        @(posedge clk_in);
        #1;
    endtask

    task automatic complete(input logic [OW-1:0] p, input logic r_run, input logic r_done);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, i, (i == 7) ? p : OW'($urandom), (i == 7) ? r_done : r_run);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [OW-1:0] held_p;
        int            cnt;
        int            mode;
        int            rdy_pct;

        // Reset with arbitrary inputs
        rst_in     = 1'b0;
        counter_in = CS'($urandom);
        product_in = OW'($urandom);
        ready_in   = 1'($urandom);
        @(posedge clk_in); #1;
        cyc(1'b0, $urandom_range(0, 7), OW'($urandom), 1'($urandom));
        check("rst valid", valid_out, 0);
        check("rst level", level_out, 0);
        check("rst overflow", overflow_out, 0);
        check("rst result", result_out, 0);

        // Single capture, consumer ready
        cyc(1'b1, 0, 0, 1'b1);
        complete(12'h0F3, 1'b1, 1'b1);
        check("single valid", valid_out, 1);
        check("single result", result_out, 12'h0F3);
        cyc(1'b1, 0, 0, 1'b1);
        check("single valid one cycle", valid_out, 0);

        // Fill, overflow, drain
        for (int k = 1; k <= 5; k++) begin
            complete(OW'(k), 1'b0, 1'b0);
            if (k == 4) begin
                check("fill level4", level_out, 4);
                check("fill no overflow", overflow_out, 0);
            end
            if (k == 5) begin
                check("overflow set", overflow_out, 1);
                check("overflow level", level_out, 4);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            check("drain order", result_out, k);
            cyc(1'b1, 0, 0, 1'b1);
        end
        check("drained valid", valid_out, 0);
        check("sticky overflow", overflow_out, 1);

        // Simultaneous push and pop while full
        cyc(1'b0, 0, 0, 1'b0);
        check("rst clears overflow", overflow_out, 0);
        for (int k = 5; k <= 8; k++) complete(OW'(k), 1'b0, 1'b0);
        complete(12'd9, 1'b0, 1'b1);
        check("pushpop level", level_out, 4);
        check("pushpop overflow", overflow_out, 0);
        for (int k = 6; k <= 9; k++) begin
            check("pushpop drain", result_out, k);
            cyc(1'b1, 0, 0, 1'b1);
        end
        check("pushpop empty", valid_out, 0);

        // Held counter gives one capture
        cyc(1'b1, 0, 0, 1'b0);
        held_p = 12'h5A5;
        cyc(1'b1, 7, held_p, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 7, OW'($urandom), 1'b0);
        check("held level", level_out, 1);
        check("held result", result_out, held_p);
        cyc(1'b1, 0, 0, 1'b0);
        check("held level after", level_out, 1);

        // Reset mid-stream discards entries
        complete(12'hAAA, 1'b0, 1'b0);
        check("midstream level", level_out, 2);
        cyc(1'b0, 0, 0, 1'b0);
        check("midstream rst level", level_out, 0);
        check("midstream rst valid", valid_out, 0);
        cyc(1'b1, 0, 0, 1'b0);

`ifdef BOOTH_COLLECT_TAG_EN
        // Tag wrap across six completions
        for (int i = 0; i < 6; i++) begin
            complete(OW'(12'h100 + i), 1'b1, 1'b1);
            check("tag seq", tag_out, i % 4);
            check("tag result", result_out, 12'h100 + i);
        end
`endif

        // Randomized traffic in blocks of differing counter and consumer behaviour
        cnt = 0;
        for (int blk = 0; blk < 60; blk++) begin
            mode    = $urandom_range(0, 2);
            rdy_pct = $urandom_range(0, 100);
            for (int i = 0; i < 64; i++) begin
                case (mode)
                    0:       cnt = (cnt + 1) % 8;
                    1:       cnt = $urandom_range(0, 7);
                    default: if ($urandom_range(0, 3) == 0) cnt = (cnt + 1) % 8;
                endcase
                cyc(!($urandom_range(0, 399) == 0), cnt, OW'($urandom),
                    $urandom_range(0, 99) < rdy_pct);
            end
        end

        @(negedge clk_in);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
